wave_capture: RTL and testbench
===============================

// Module: wave_capture
// PURPOSE
//  Trigger-qualified capture buffer downstream of the waveform sample generator.
//  - Consumes its per-cycle random byte plus free-running 32-bit counter as a timestamp.
//  - Waits for a masked trigger match, stores DEPTH consecutive valid samples with
//    their stamps, then drains them over a valid/ready read port.
//  - Gives the waveform environment a deterministic, checkable snapshot of the stimulus.
// PARAMETERS
//  DW     8   sample data width
//  SW     32  timestamp width; matches the generator counter
//  DEPTH  16  samples per capture; power of 2, >= 2
//  AW     $clog2(DEPTH)  address width; localparam, not overridable
// PORTS
//  clk           in   1       single clock; all logic on posedge
//  rst           in   1       synchronous, active-high reset
//  arm           in   1       pulse: IDLE -> ARMED
//  abort         in   1       pulse: any state -> IDLE, capture discarded
//  trig_value    in   DW      trigger compare value
//  trig_mask     in   DW      1 = bit participates in compare; all-0 = trigger on first valid
//  sample_valid  in   1       sample_data/sample_stamp valid this cycle
//  sample_data   in   DW      sample (generator random byte)
//  sample_stamp  in   SW      sample timestamp (generator counter)
//  rd_valid      out  1       rd_data/rd_stamp hold a buffered entry
//  rd_ready      in   1       consumer accepts entry when rd_valid & rd_ready
//  rd_data       out  DW      buffered sample, oldest first
//  rd_stamp      out  SW      stamp of rd_data
//  trig_stamp    out  SW      stamp of the triggering sample
//  busy          out  1       state != IDLE
//  done          out  1       1-cycle pulse after last read transfer
//  drop_cnt      out  16      valid samples seen in READOUT; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset:
//  - state = IDLE; wr_ptr = rd_ptr = 0.
//  - rd_valid = busy = done = 0; trig_stamp = 0; drop_cnt = 0.
//  - Buffer contents are don't-care after reset.
//  Trigger match: ((sample_data ^ trig_value) & trig_mask) == 0, qualified by sample_valid.
//  States:
//  - IDLE:    arm -> ARMED; samples ignored.
//  - ARMED:   on match:
//             - write entry 0 and latch trig_stamp on the same edge;
//             - wr_ptr = 1; -> CAPTURE.
//             - Non-matching samples are discarded.
//  - CAPTURE: each sample_valid writes mem[wr_ptr] and increments wr_ptr; no match needed.
//             - Write at wr_ptr == DEPTH-1 -> READOUT, rd_ptr = 0.
//             - Cycles with sample_valid = 0 write nothing.
//  - READOUT: rd_valid = 1; rd_data/rd_stamp = mem[rd_ptr].
//             - Output is first-word-fallthrough, combinational from the buffer.
//             - Holds stable while rd_valid & !rd_ready.
//             - Each transfer increments rd_ptr.
//             - Transfer at rd_ptr == DEPTH-1 -> IDLE; done = 1 on the next cycle only.
//             - sample_valid increments drop_cnt.
//  Timing:
//  - Trigger sample to first rd_valid: DEPTH-1 further valid samples + 1 cycle.
//  - Full drain at rd_ready = 1: DEPTH cycles.
//  Boundary rules:
//  - abort beats every other event in the same cycle; next state IDLE.
//    - rd_valid drops the next cycle; done is not pulsed; drop_cnt unchanged.
//  - arm outside IDLE is ignored. arm with abort in IDLE -> stays IDLE.
//  - arm in the same cycle as the final read transfer is ignored (state still READOUT).
//  - drop_cnt clears only on rst or on IDLE->ARMED; holds at 16'hFFFF.
//  - rst mid-capture or mid-readout: all outputs reach reset values on the next edge;
//    no done pulse.
//  - Pointer arithmetic is AW bits; no wrap occurs within a capture (bounded by DEPTH-1).
// TESTING (DW=8, DEPTH=16)
//  1. rst held 3 cycles, then released -> busy=0, rd_valid=0, done=0, drop_cnt=0.
//  2. Flow: arm; mask=FF, value=A5; stream d=stamp[7:0] with a 3C at stamp 100 and
//     A5 at stamp 105 -> trig_stamp=105; 16 reads give stamps 105..120 in order;
//     done one cycle after the 16th read.
//  3. Hold then drop: rd_ready=0 for 10 cycles in READOUT with 7 valid samples ->
//     rd_data/rd_stamp stable; drop_cnt=7; then rd_ready=1 -> 16 transfers.
//  4. Gapped input: sample_valid toggling 1,0,1,0 in CAPTURE -> only valid samples stored;
//     stored stamps are every other value.
//  5. Abort timing: abort at capture entry 9 -> IDLE next cycle, no rd_valid, no done.
//     Abort on read 4 -> rd_valid low next cycle.
//  6. mask=00 -> first valid sample after arm triggers.
//     Arm in ARMED/READOUT -> no state change.
//     rst mid-READOUT -> reset values next cycle.

Source files
------------

// File: rtl/wave_capture.sv
// Trigger-qualified capture buffer: waits for a masked match, stores DEPTH samples
// with their timestamps, then drains them oldest-first over a valid/ready port.
module wave_capture #(
  parameter int unsigned DW    = 8,
  parameter int unsigned SW    = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          arm_i,
  input  logic          abort_i,
  input  logic [DW-1:0] trig_value_i,
  input  logic [DW-1:0] trig_mask_i,
  input  logic          sample_valid_i,
  input  logic [DW-1:0] sample_data_i,
  input  logic [SW-1:0] sample_stamp_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [DW-1:0] rd_data_o,
  output logic [SW-1:0] rd_stamp_o,
  output logic [SW-1:0] trig_stamp_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [15:0]   drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PtrOne  = AW'(1);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StReadout} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] trig_stamp_q, trig_stamp_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          done_q, done_d;

  logic [DW-1:0] mem_data_q  [DEPTH];
  logic [SW-1:0] mem_stamp_q [DEPTH];

  logic          match;
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign match = sample_valid_i && (((sample_data_i ^ trig_value_i) & trig_mask_i) == '0);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    trig_stamp_d = trig_stamp_q;
    drop_cnt_d   = drop_cnt_q;
    done_d       = 1'b0;
    wr_en        = 1'b0;
    wr_addr      = wr_ptr_q;

    unique case (state_q)
      StIdle: begin
        if (arm_i) begin
          state_d    = StArmed;
          drop_cnt_d = '0;
        end
      end
      StArmed: begin
        if (match) begin
          wr_en        = 1'b1;
          wr_addr      = '0;
          wr_ptr_d     = PtrOne;
          trig_stamp_d = sample_stamp_i;
          state_d      = StCapture;
        end
      end
      StCapture: begin
        if (sample_valid_i) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + PtrOne;
          if (wr_ptr_q == LastIdx) begin
            state_d  = StReadout;
            rd_ptr_d = '0;
          end
        end
      end
      StReadout: begin
        if (sample_valid_i && (drop_cnt_q != 16'hFFFF)) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
        if (rd_ready_i) begin
          rd_ptr_d = rd_ptr_q + PtrOne;
          if (rd_ptr_q == LastIdx) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides every other event and leaves counters/stamp untouched.
    if (abort_i) begin
      state_d      = StIdle;
      wr_en        = 1'b0;
      done_d       = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      trig_stamp_d = trig_stamp_q;
      drop_cnt_d   = drop_cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      trig_stamp_q <= '0;
      drop_cnt_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      trig_stamp_q <= trig_stamp_d;
      drop_cnt_q   <= drop_cnt_d;
      done_q       <= done_d;
    end
  end

  // Buffer storage carries no reset; contents are only read after a full capture.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) begin
      mem_data_q[wr_addr]  <= sample_data_i;
      mem_stamp_q[wr_addr] <= sample_stamp_i;
    end
  end

  assign rd_valid_o   = (state_q == StReadout);
  assign rd_data_o    = mem_data_q[rd_ptr_q];
  assign rd_stamp_o   = mem_stamp_q[rd_ptr_q];
  assign trig_stamp_o = trig_stamp_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: directed scenarios plus randomized captures
// checked against a queue-based reference of the expected snapshot.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  trig_value = 8'h00;
  logic [7:0]  trig_mask = 8'h00;
  logic        sample_valid = 1'b0;
  logic [7:0]  sample_data = 8'h00;
  logic [31:0] sample_stamp = 32'd0;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic [7:0]  rd_data;
  logic [31:0] rd_stamp;
  logic [31:0] trig_stamp;
  logic        busy;
  logic        done;
  logic [15:0] drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  wave_capture #(.DW(8), .SW(32), .DEPTH(16)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .arm_i         (arm),
    .abort_i       (abort),
    .trig_value_i  (trig_value),
    .trig_mask_i   (trig_mask),
    .sample_valid_i(sample_valid),
    .sample_data_i (sample_data),
    .sample_stamp_i(sample_stamp),
    .rd_valid_o    (rd_valid),
    .rd_ready_i    (rd_ready),
    .rd_data_o     (rd_data),
    .rd_stamp_o    (rd_stamp),
    .trig_stamp_o  (trig_stamp),
    .busy_o        (busy),
    .done_o        (done),
    .drop_cnt_o    (drop_cnt)
  );

  always #5 clk = ~clk;

  // One clock; outputs observed 1ns after the edge, stamp advances like a free counter.
  task automatic tick();
    @(posedge clk);
    #1;
    sample_stamp = sample_stamp + 32'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({busy, rd_valid, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {busy, rd_valid, done});
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if ({busy, rd_valid, done} !== 3'b000) begin
      n_fail++; $display("FAIL post_reset_flags: got %b want 000", {busy, rd_valid, done});
    end
    n_checks++;
    if (drop_cnt !== 16'd0 || trig_stamp !== 32'd0) begin
      n_fail++; $display("FAIL reset_counters: drop %0d stamp %0d want 0 0", drop_cnt, trig_stamp);
    end
  endtask

  task automatic test_flow();
    logic [31:0] last;
    logic [31:0] s;
    logic [7:0]  d;
    int          cyc;
    sample_stamp = 32'd90;
    trig_mask = 8'hFF; trig_value = 8'hA5;
    arm = 1'b1; tick(); arm = 1'b0;
    cyc = 0; last = 32'd0;
    while (!rd_valid && cyc < 60) begin
      sample_valid = 1'b1;
      sample_data = (sample_stamp == 32'd100) ? 8'h3C :
                    (sample_stamp == 32'd105) ? 8'hA5 : sample_stamp[7:0];
      last = sample_stamp;
      tick(); cyc++;
    end
    sample_valid = 1'b0;
    n_checks++;
    if (last !== 32'd120) begin
      n_fail++; $display("FAIL flow_latency: rd_valid after stamp %0d want 120", last);
    end
    n_checks++;
    if (trig_stamp !== 32'd105) begin
      n_fail++; $display("FAIL flow_trig_stamp: got %0d want 105", trig_stamp);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s = 32'd105 + 32'(i);
      d = (i == 0) ? 8'hA5 : s[7:0];
      n_checks++;
      if (rd_valid !== 1'b1 || rd_stamp !== s || rd_data !== d) begin
        n_fail++;
        $display("FAIL flow_read%0d: v %b stamp %0d data %h want 1 %0d %h",
                 i, rd_valid, rd_stamp, rd_data, s, d);
      end
      tick();
    end
    rd_ready = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL flow_done: done %b busy %b want 1 0", done, busy);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL flow_done_pulse: done %b want 0", done);
    end
  endtask

  // Randomized capture; vpct < 0 selects strictly alternating sample_valid.
  task automatic run_capture(input logic [7:0] mask, input logic [7:0] value, input int vpct,
                             input int rpct, input int dpct, input int hold, input string name);
    logic [7:0]  qd[$];
    logic [31:0] qs[$];
    logic [31:0] exp_trig;
    bit          trig;
    int          cyc;
    int          drops;
    int          n;
    trig_mask = mask; trig_value = value;
    sample_valid = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || drop_cnt !== 16'd0) begin
      n_fail++; $display("FAIL %s_armed: busy %b drop %0d want 1 0", name, busy, drop_cnt);
    end
    trig = 1'b0; cyc = 0; exp_trig = 32'd0;
    while (qd.size() < 16 && cyc < 2000) begin
      sample_valid = (vpct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < vpct);
      sample_data = ($urandom_range(7) == 0) ? (value ^ (~mask & 8'($urandom))) : 8'($urandom);
      if (sample_valid && (trig || ((sample_data ^ value) & mask) == 8'h00)) begin
        if (!trig) exp_trig = sample_stamp;
        trig = 1'b1;
        qd.push_back(sample_data);
        qs.push_back(sample_stamp);
      end
      tick(); cyc++;
      if (qd.size() < 16) begin
        n_checks++;
        if (rd_valid !== 1'b0) begin
          n_fail++; $display("FAIL %s_early_valid: rd_valid %b want 0 at %0d", name, rd_valid, cyc);
        end
      end
    end
    sample_valid = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b1 || trig_stamp !== exp_trig) begin
      n_fail++;
      $display("FAIL %s_capture: v %b trig %0d want 1 %0d", name, rd_valid, trig_stamp, exp_trig);
    end
    if (qd.size() < 16) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: captured %0d want 16", name, qd.size());
      return;
    end
    drops = 0;
    rd_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      sample_valid = (i < 7);
      if (sample_valid) drops++;
      tick();
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== qd[0] || rd_stamp !== qs[0]) begin
        n_fail++;
        $display("FAIL %s_hold: v %b data %h stamp %0d want 1 %h %0d",
                 name, rd_valid, rd_data, rd_stamp, qd[0], qs[0]);
      end
    end
    n = 0;
    while (n < 16 && cyc < 4000) begin
      sample_valid = ($urandom_range(99) < dpct);
      rd_ready = ($urandom_range(99) < rpct);
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== qd[n] || rd_stamp !== qs[n]) begin
        n_fail++;
        $display("FAIL %s_read%0d: v %b data %h stamp %0d want 1 %h %0d",
                 name, n, rd_valid, rd_data, rd_stamp, qd[n], qs[n]);
      end
      if (sample_valid) drops++;
      if (rd_ready) n++;
      tick(); cyc++;
    end
    sample_valid = 1'b0; rd_ready = 1'b0;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || drop_cnt !== 16'(drops)) begin
      n_fail++;
      $display("FAIL %s_end: done %b busy %b v %b drop %0d want 1 0 0 %0d",
               name, done, busy, rd_valid, drop_cnt, drops);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL %s_done_pulse: done %b want 0", name, done);
    end
  endtask

  task automatic test_random();
    run_capture(8'hFF, 8'($urandom), 100, 100, 0, 0, "full_rate");
    run_capture(8'hF0, 8'($urandom), 70, 60, 30, 0, "random_mix");
    run_capture(8'h00, 8'($urandom), 50, 40, 50, 0, "mask_zero");
  endtask

  task automatic test_hold_drop();
    run_capture(8'h3C, 8'($urandom), 100, 100, 0, 10, "hold_drop");
  endtask

  task automatic test_gapped();
    run_capture(8'hFF, 8'($urandom), -1, 100, 0, 0, "gapped");
  endtask

  task automatic test_abort();
    bit bad;
    trig_mask = 8'h00; sample_valid = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    sample_valid = 1'b1;
    repeat (9) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_capture: busy %b v %b want 0 0", busy, rd_valid);
    end
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (rd_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++; $display("FAIL abort_idle: v %b done %b busy %b want 0 0 0", rd_valid, done, busy);
    end
    sample_valid = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    sample_valid = 1'b1;
    repeat (16) tick();
    sample_valid = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b1) begin
      n_fail++; $display("FAIL abort_setup: rd_valid %b want 1", rd_valid);
    end
    rd_ready = 1'b1;
    repeat (4) tick();
    abort = 1'b1; sample_valid = 1'b1;
    tick();
    abort = 1'b0; sample_valid = 1'b0; rd_ready = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || drop_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_read: v %b busy %b done %b drop %0d want 0 0 0 0",
               rd_valid, busy, done, drop_cnt);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done: done %b want 0", done);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] s;
    arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL arm_abort_idle: busy %b want 0", busy);
    end
    trig_mask = 8'hFF; trig_value = 8'hA5; sample_data = 8'h00;
    arm = 1'b1; tick();
    sample_valid = 1'b1; tick();
    arm = 1'b0; sample_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL arm_in_armed: busy %b v %b want 1 0", busy, rd_valid);
    end
    trig_mask = 8'h00;
    sample_valid = 1'b1; sample_data = 8'($urandom); s = sample_stamp;
    tick();
    n_checks++;
    if (trig_stamp !== s) begin
      n_fail++; $display("FAIL mask00_trigger: stamp %0d want %0d", trig_stamp, s);
    end
    repeat (15) tick();
    sample_valid = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_stamp !== s) begin
      n_fail++; $display("FAIL arm_in_readout: v %b stamp %0d want 1 %0d", rd_valid, rd_stamp, s);
    end
    rd_ready = 1'b1;
    repeat (15) tick();
    arm = 1'b1; tick(); arm = 1'b0; rd_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++; $display("FAIL arm_on_final_read: busy %b done %b want 0 1", busy, done);
    end
    tick();
    arm = 1'b1; tick(); arm = 1'b0;
    sample_valid = 1'b1;
    repeat (19) tick();
    n_checks++;
    if (rd_valid !== 1'b1 || drop_cnt !== 16'd3) begin
      n_fail++; $display("FAIL rst_setup: v %b drop %0d want 1 3", rd_valid, drop_cnt);
    end
    rd_ready = 1'b1; tick();
    rst = 1'b1; tick(); rst = 1'b0;
    rd_ready = 1'b0; sample_valid = 1'b0;
    n_checks++;
    if ({busy, rd_valid, done} !== 3'b000 || drop_cnt !== 16'd0 || trig_stamp !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_readout: flags %b drop %0d stamp %0d want 000 0 0",
               {busy, rd_valid, done}, drop_cnt, trig_stamp);
    end
    tick();
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL rst_no_done: done %b want 0", done);
    end
  endtask

  initial begin
    test_reset();
    test_flow();
    test_hold_drop();
    test_gapped();
    test_random();
    test_abort();
    test_boundaries();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
